dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port synchronous data RAM between the CPU data port and a second bus master (DMA/IO engine).
- Sits between the control/datapath dMem signals and d_ram.
- The CPU has fixed priority. A wait counter guarantees DMA forward progress.
- Read data is routed back to the requester that owned the access, one cycle after the grant, matching d_ram's registered read.

Parameters:
ADDR_W, 16, address width of both requesters and the RAM
DATA_W, 8, data width
MAX_WAIT, 4, consecutive denied DMA-request cycles after which DMA wins the next contested cycle (legal range 1..15)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cpu_req  in  1  CPU access request, valid this cycle
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_stall  out  1  CPU request present but not granted this cycle
cpu_rdata  out  DATA_W  CPU read data
cpu_rvalid  out  1  cpu_rdata valid (one-cycle pulse)
dma_req  in  1  DMA request; must be held stable until dma_gnt
dma_we  in  1  1 = write, 0 = read
dma_addr  in  ADDR_W  DMA address
dma_wdata  in  DATA_W  DMA write data
dma_gnt  out  1  DMA access issued this cycle
dma_rdata  out  DATA_W  DMA read data
dma_rvalid  out  1  dma_rdata valid (one-cycle pulse)
mem_addr  out  ADDR_W  to d_ram w_addr/r_addr
mem_din  out  DATA_W  to d_ram din
mem_w_en  out  1  to d_ram w_en
mem_r_en  out  1  to d_ram r_en
mem_dout  in  DATA_W  from d_ram dout

Behaviour:
- Clock/reset: one clock domain (clk); rst is synchronous and active-high.
- State registers:
  - wait_cnt (4 bit)
  - rd_owner (1 bit: 0 = CPU, 1 = DMA)
  - rd_pend (1 bit)
- Reset values:
  - wait_cnt = 0, rd_pend = 0, rd_owner = 0.
  - cpu_rvalid = dma_rvalid = 0.
  - While rst is high: cpu_stall = 0, dma_gnt = 0, mem_w_en = mem_r_en = 0, mem_addr = 0, mem_din = 0.
- Grant decision is combinational in the same cycle:
  - Only cpu_req: CPU granted.
  - Only dma_req: DMA granted.
  - Both, wait_cnt < MAX_WAIT: CPU granted.
  - Both, wait_cnt >= MAX_WAIT: DMA granted.
  - Neither: idle. mem_w_en = mem_r_en = 0; mem_addr/mem_din hold the CPU fields.
- Issue: the granted master's addr/wdata drive mem_addr/mem_din.
  - Write: mem_w_en = 1.
  - Read: mem_r_en = 1.
  - Exactly one of mem_w_en/mem_r_en is high for any grant.
- Stall flags:
  - cpu_stall = cpu_req & ~cpu_granted.
  - dma_gnt = dma_req & dma_granted.
- wait_cnt update:
  - dma_req & ~dma_gnt: increment, saturating at 15.
  - dma_gnt or ~dma_req: clear to 0.
- Read return (latency 1):
  - On a granted read, next cycle rd_pend = 1 and rd_owner = the granted master.
  - While rd_pend is high, the owner's rvalid = 1 and its rdata = mem_dout.
  - The other master's rdata holds its last value.
- Back-to-back reads are fully pipelined: a new grant may issue in the same cycle a previous read returns.
- A write never raises rvalid.
- Simultaneous write and read to the same address by different masters in consecutive cycles: plain sequential RAM semantics. A read in the cycle after a write sees the new data.
- Reset during a pending read: rd_pend is cleared and no rvalid is emitted.
- The CPU request is not required to be held. A stalled CPU keeps cpu_req asserted by construction of the control FSM.
- DMA dropping dma_req before grant is a protocol violation. The arbiter clears wait_cnt and asserts nothing.

Test Plan:
1. CPU-only write then read: write 0xA5 to 0x0040, then read 0x0040 -> mem_w_en 1 for one cycle; next access mem_r_en 1; cpu_rvalid 1 exactly one cycle later with cpu_rdata = 0xA5; dma_rvalid stays 0.
2. DMA-only read of 0x1234, preloaded with 0x3C -> dma_gnt 1 in the request cycle; dma_rvalid 1 the next cycle with dma_rdata = 0x3C.
3. Contention, MAX_WAIT = 4, cpu_req and dma_req held continuously -> CPU granted cycles 0–3 (wait_cnt 1,2,3,4); cycle 4 dma_gnt = 1, cpu_stall = 1; cycle 5 CPU granted, wait_cnt = 0; pattern repeats with period 5.
4. Pipelined routing: CPU read 0x0010 (=0x11) in cycle 0, DMA read 0x0020 (=0x22) in cycle 1 -> cycle 1 cpu_rvalid with 0x11; cycle 2 dma_rvalid with 0x22; never both rvalids high.
5. Reset mid-read: DMA read granted at cycle 0, rst high at cycle 1 -> dma_rvalid = 0 in cycles 1–2; wait_cnt = 0; mem enables 0 while rst is high.
6. Idle and write-only traffic: neither request -> both mem enables 0; DMA writes 0x7E to 0x00FF -> dma_gnt 1, no rvalid; a following CPU read returns 0x7E.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port synchronous data RAM between the CPU data
// port and a second bus master (DMA/IO engine).
//
// The CPU has fixed priority. A counter of consecutive denied DMA cycles lets the
// DMA win a contested cycle once it reaches MAX_WAIT, so the DMA always makes
// progress. Read data returns one cycle after the grant, which matches the
// registered read of d_ram. It is steered to the master that issued the read.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   cpu_req/we/addr/wdata        CPU access request (need not be held)
//   cpu_stall                    CPU request present but not granted
//   cpu_rdata/cpu_rvalid         CPU read return (rvalid is a one-cycle pulse)
//   dma_req/we/addr/wdata        DMA access request (held until dma_gnt)
//   dma_gnt                      DMA access issued this cycle
//   dma_rdata/dma_rvalid         DMA read return (rvalid is a one-cycle pulse)
//   mem_addr/din/w_en/r_en       to d_ram
//   mem_dout                     from d_ram (registered read data)
module dmem_arbiter #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,

  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid,

  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_w_en,
  output logic              mem_r_en,
  input  logic [DATA_W-1:0] mem_dout
);

  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_owner_q, rd_owner_d;   // 0 = CPU, 1 = DMA
  logic [DATA_W-1:0] cpu_rdata_q, dma_rdata_q;

  logic dma_priority;
  logic dma_sel;
  logic cpu_sel;
  logic any_sel;
  logic sel_we;
  logic rd_issue;

  // Grant decision and RAM issue. Everything is forced to zero while rst is high.
  always_comb begin
    dma_priority = (wait_cnt_q >= 4'(MAX_WAIT));
    dma_sel      = ~rst & dma_req & (~cpu_req | dma_priority);
    cpu_sel      = ~rst & cpu_req & ~dma_sel;
    any_sel      = cpu_sel | dma_sel;
    sel_we       = dma_sel ? dma_we : cpu_we;
    rd_issue     = any_sel & ~sel_we;

    cpu_stall = ~rst & cpu_req & ~cpu_sel;
    dma_gnt   = dma_sel;

    // When the arbiter is idle, the address and data buses carry the CPU fields.
    if (rst) begin
      mem_addr = '0;
      mem_din  = '0;
    end else if (dma_sel) begin
      mem_addr = dma_addr;
      mem_din  = dma_wdata;
    end else begin
      mem_addr = cpu_addr;
      mem_din  = cpu_wdata;
    end
    mem_w_en = any_sel & sel_we;
    mem_r_en = rd_issue;
  end

  // Read return. Gating with rst suppresses a return that was pending at reset.
  always_comb begin
    cpu_rvalid = ~rst & rd_pend_q & ~rd_owner_q;
    dma_rvalid = ~rst & rd_pend_q & rd_owner_q;
    cpu_rdata  = cpu_rvalid ? mem_dout : cpu_rdata_q;
    dma_rdata  = dma_rvalid ? mem_dout : dma_rdata_q;
  end

  // Next state.
  always_comb begin
    wait_cnt_d = '0;
    if (dma_req && !dma_sel) begin
      wait_cnt_d = (wait_cnt_q == 4'hF) ? 4'hF : wait_cnt_q + 4'd1;
    end
    rd_pend_d  = rd_issue;
    rd_owner_d = rd_issue ? dma_sel : rd_owner_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q  <= '0;
      rd_pend_q   <= 1'b0;
      rd_owner_q  <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
      // Capture returned data so the idle master's rdata holds its last value.
      if (cpu_rvalid) cpu_rdata_q <= mem_dout;
      if (dma_rvalid) dma_rdata_q <= mem_dout;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter. A behavioural d_ram drives mem_dout. The reference
// model applies the arbitration rules to the inputs of each cycle. It checks the
// grant and issue outputs and queues the expected read returns. A separate
// monitor pops that queue whenever an rvalid appears.
module tb_dmem_arbiter;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;
  localparam int unsigned MW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, cpu_stall, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dma_req, dma_we, dma_gnt, dma_rvalid;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata, dma_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          mem_w_en, mem_r_en;
  logic [DW-1:0] mem_dout = '0;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_w_en(mem_w_en), .mem_r_en(mem_r_en),
    .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // d_ram stand-in: synchronous write, registered read.
  logic [DW-1:0] ram     [0:65535];
  logic [DW-1:0] ref_mem [0:65535];
  always @(posedge clk) begin
    if (mem_w_en) ram[mem_addr] <= mem_din;
    if (mem_r_en) mem_dout <= ram[mem_addr];
  end

  typedef struct {
    bit            owner;   // 0 = CPU, 1 = DMA
    logic [DW-1:0] data;
    int            due;
  } rd_t;
  rd_t sb_q[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int waits    = 0;
  bit last_dma_gnt = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: expected grant/issue for this cycle, plus the expected
  // read-return queue.
  always @(negedge clk) begin : model
    bit dw, cw, gnt, we;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    if (rst) begin
      check("rst_dma_gnt", dma_gnt, 0);
      check("rst_cpu_stall", cpu_stall, 0);
      check("rst_w_en", mem_w_en, 0);
      check("rst_r_en", mem_r_en, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_din", mem_din, 0);
      waits = 0;
      last_dma_gnt = 1'b0;
    end else begin
      dw  = dma_req && (!cpu_req || waits >= int'(MW));
      cw  = cpu_req && !dw;
      gnt = dw || cw;
      we  = dw ? dma_we : cpu_we;
      ea  = dw ? dma_addr : cpu_addr;
      ed  = dw ? dma_wdata : cpu_wdata;
      check("dma_gnt", dma_gnt, dw);
      check("cpu_stall", cpu_stall, cpu_req && !cw);
      check("mem_addr", mem_addr, ea);
      check("mem_din", mem_din, ed);
      check("mem_w_en", mem_w_en, gnt && we);
      check("mem_r_en", mem_r_en, gnt && !we);
      if (gnt && we) ref_mem[ea] = ed;
      if (gnt && !we) sb_q.push_back('{owner: dw, data: ref_mem[ea], due: cyc + 1});
      waits = (dma_req && !dw) ? ((waits < 15) ? waits + 1 : 15) : 0;
      last_dma_gnt = dw;
    end
  end

  // Monitor: checks read returns against the queue and checks that the rdata
  // of the master without a return holds its value.
  bit            cpu_known = 1'b0, dma_known = 1'b0;
  logic [DW-1:0] cpu_hold, dma_hold;
  always @(negedge clk) begin : monitor
    rd_t e;
    check("rvalid_exclusive", {31'd0, cpu_rvalid && dma_rvalid}, 0);
    if (rst) begin
      check("rst_cpu_rvalid", cpu_rvalid, 0);
      check("rst_dma_rvalid", dma_rvalid, 0);
      while (sb_q.size() > 0 && sb_q[0].due <= cyc) void'(sb_q.pop_front());
      cpu_known = 1'b0;
      dma_known = 1'b0;
    end else if (cpu_rvalid || dma_rvalid) begin
      if (sb_q.size() == 0) begin
        check("spurious_rvalid", {cpu_rvalid, dma_rvalid}, 0);
      end else begin
        e = sb_q.pop_front();
        check("rd_latency", e.due, cyc);
        check("rd_owner", {31'd0, dma_rvalid}, {31'd0, e.owner});
        check("rd_data", dma_rvalid ? dma_rdata : cpu_rdata, e.data);
        if (dma_rvalid) begin dma_hold = e.data; dma_known = 1'b1; end
        else begin cpu_hold = e.data; cpu_known = 1'b1; end
      end
    end else if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      e = sb_q.pop_front();
      check("missed_rvalid", 0, 1);
    end
    if (!rst && !cpu_rvalid && cpu_known) check("cpu_rdata_hold", cpu_rdata, cpu_hold);
    if (!rst && !dma_rvalid && dma_known) check("dma_rdata_hold", dma_rdata, dma_hold);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_set(input bit req, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic dma_set(input bit req, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    dma_req = req; dma_we = we; dma_addr = a; dma_wdata = d;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      ram[i] = '0;
      ref_mem[i] = '0;
    end
    ram[16'h1234] = 8'h3C; ref_mem[16'h1234] = 8'h3C;
    ram[16'h0010] = 8'h11; ref_mem[16'h0010] = 8'h11;
    ram[16'h0020] = 8'h22; ref_mem[16'h0020] = 8'h22;

    rst = 1'b1;
    cpu_set(0, 0, 16'h0, 8'h0);
    dma_set(0, 0, 16'h0, 8'h0);
    step(); step();
    rst = 1'b0;

    // CPU-only write, then a read of the same address.
    cpu_set(1, 1, 16'h0040, 8'hA5); step();
    cpu_set(1, 0, 16'h0040, 8'h00); step();
    cpu_set(0, 0, 16'h0000, 8'h00); step();

    // DMA-only read of preloaded data.
    dma_set(1, 0, 16'h1234, 8'h00); step();
    dma_set(0, 0, 16'h0000, 8'h00); step();

    // Sustained contention: the DMA wins one cycle in every MAX_WAIT+1.
    cpu_set(1, 0, 16'h0040, 8'h00);
    dma_set(1, 0, 16'h1234, 8'h00);
    repeat (12) step();
    cpu_set(0, 0, 16'h0, 8'h0);
    dma_set(0, 0, 16'h0, 8'h0);
    step();

    // Pipelined routing: a CPU read followed by a DMA read.
    cpu_set(1, 0, 16'h0010, 8'h00); step();
    cpu_set(0, 0, 16'h0000, 8'h00);
    dma_set(1, 0, 16'h0020, 8'h00); step();
    dma_set(0, 0, 16'h0000, 8'h00); step();

    // Reset while a DMA read is pending.
    dma_set(1, 0, 16'h1234, 8'h00); step();
    dma_set(0, 0, 16'h0000, 8'h00);
    rst = 1'b1; step();
    rst = 1'b0; step();

    // Idle, then a DMA write followed by a CPU read of the same address.
    step();
    dma_set(1, 1, 16'h00FF, 8'h7E); step();
    dma_set(0, 0, 16'h0000, 8'h00);
    cpu_set(1, 0, 16'h00FF, 8'h00); step();
    cpu_set(0, 0, 16'h0000, 8'h00); step();

    // Randomized traffic. The DMA holds each request until it is granted.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      cpu_set(bit'($urandom_range(0, 99) < 60), bit'($urandom_range(0, 1)),
              AW'($urandom_range(0, 31)), DW'($urandom));
      if (!dma_req || last_dma_gnt) begin
        dma_set(bit'($urandom_range(0, 99) < 50), bit'($urandom_range(0, 1)),
                AW'($urandom_range(0, 31)), DW'($urandom));
      end
      step();
    end
    rst = 1'b0;
    cpu_set(0, 0, 16'h0, 8'h0);
    dma_set(0, 0, 16'h0, 8'h0);
    repeat (4) step();
    check("queue_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
